// File: rtl/muldiv_pkg.sv
// Shared ALU codes and FSM state encoding for the HI/LO multiply/divide engine.
package muldiv_pkg;

  localparam logic [3:0] ALU_MULU = 4'b1100;
  localparam logic [3:0] ALU_DIVU = 4'b1101;
  localparam logic [3:0] ALU_MULT = 4'b1110;
  localparam logic [3:0] ALU_DIV  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             div_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    acc_o   = acc_i;
    q_o     = q_i;
    sum     = q_i[0] ? ({1'b0, acc_i} + {1'b0, opnd_i}) : {1'b0, acc_i};
    shifted = {acc_i, q_i[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    if (div_i) begin
      // Borrow out of the trial subtract means the divisor did not fit: restore.
      if (!diff[WIDTH+1]) begin
        acc_o = diff[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide: WIDTH+2 cycle latency, stall while a read or start meets busy.
// Define MULDIV_EARLY_OUT_EN to let zero operands skip ITER (2-cycle latency).
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       con,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hiloR,
  input  logic             hiloS,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             divz
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic             negp_q, negp_d;
  logic             negr_q, negr_d;
  logic             zdiv_q, zdiv_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;

  logic             code_ok, is_div, is_sgn, sa, sb;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH-1:0] step_acc, step_q;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo, rem;

  assign code_ok = (con == ALU_MULU) || (con == ALU_DIVU) || (con == ALU_MULT) || (con == ALU_DIV);
  assign is_div  = (con == ALU_DIVU) || (con == ALU_DIV);
  assign is_sgn  = (con == ALU_MULT) || (con == ALU_DIV);
  assign sa      = is_sgn & a[WIDTH-1];
  assign sb      = is_sgn & b[WIDTH-1];
  assign ma      = sa ? -a : a;
  assign mb      = sb ? -b : b;

  assign prod   = {acc_q, q_q};
  assign prod_s = negp_q ? -prod : prod;
  assign quo    = negp_q ? -q_q : q_q;
  assign rem    = negr_q ? -acc_q : acc_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .q_i    (q_q),
    .opnd_i (opnd_q),
    .div_i  (div_q),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    q_d     = q_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    zdiv_d  = zdiv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush && code_ok) begin
          count_d = '0;
          acc_d   = '0;
          q_d     = is_div ? ma : mb;
          opnd_d  = is_div ? mb : ma;
          div_d   = is_div;
          negp_d  = sa ^ sb;
          negr_d  = sa;
          zdiv_d  = is_div && (b == '0);
          state_d = ITER;
`ifdef MULDIV_EARLY_OUT_EN
          // Preload exactly what WIDTH iterations would have produced.
          if (is_div && (b == '0)) begin
            acc_d   = ma;
            q_d     = '1;
            state_d = FIX;
          end else if (!is_div && ((a == '0) || (b == '0))) begin
            q_d     = '0;
            state_d = FIX;
          end
`endif
        end
      end
      ITER: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = step_acc;
          q_d     = step_q;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          if (div_q) begin
            hi_d = rem;
            lo_d = zdiv_q ? '1 : quo;
          end else begin
            {hi_d, lo_d} = prod_s;
          end
          done_d = 1'b1;
          divz_d = zdiv_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      zdiv_q  <= zdiv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy & (hiloR | start);
  assign rdata = hiloS ? lo_q : hi_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign divz  = divz_q;

endmodule
